// File: rtl/counter_pkg.sv
// Shared definitions for the counter block and its consumers.
//   CounterBw  : default timestamp/counter width, shared with the counter block.
//   clog2      : ceiling log2 usable in constant expressions.
//   fill_width : width of an occupancy counter spanning 0..depth.
package counter_pkg;

  localparam int unsigned CounterBw = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((res < 32) && ((32'd1 << res) < value)) begin
      res++;
    end
    return res;
  endfunction

  // Occupancy counters must hold the value depth itself, hence the extra bit.
  function automatic int unsigned fill_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into the clk_i domain and emits a
// single-cycle pulse on each synchronised rising edge.
//   clk_i   : sampling clock
//   rst_i   : asynchronous active-high reset; clears chain and history
//   async_i : asynchronous input level
//   rise_o  : high for one cycle per rising edge of the synchronised level
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History resets low, so a level held high through reset release yields one pulse.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/counter_capture_fifo.sv
// Timestamps rising edges of an asynchronous event with the free-running
// counter value and buffers them in a first-word-fall-through FIFO.
//   clk_i         : system clock, shared with the counter
//   rst_i         : asynchronous active-high reset
//   counter_val_i : timestamp source (counter output)
//   event_i       : asynchronous event; each rising edge requests a capture
//   ts_data_o     : head-of-FIFO timestamp, 0 when empty
//   ts_valid_o    : head entry valid
//   ts_ready_i    : consumer accepts head entry
//   fill_o        : occupancy 0..DEPTH
//   overflow_o    : sticky, a capture was dropped because the FIFO was full
//   clear_ovf_i   : synchronous clear of overflow_o (a same-edge drop wins)
module counter_capture_fifo
  import counter_pkg::*;
#(
  parameter int unsigned BW          = CounterBw,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BW-1:0]                 counter_val_i,
  input  logic                          event_i,
  output logic [BW-1:0]                 ts_data_o,
  output logic                          ts_valid_o,
  input  logic                          ts_ready_i,
  output logic [fill_width(DEPTH)-1:0]  fill_o,
  output logic                          overflow_o,
  input  logic                          clear_ovf_i
);

  localparam int unsigned PtrW  = clog2(DEPTH);
  localparam int unsigned FillW = fill_width(DEPTH);
  localparam logic [FillW-1:0] FillFull = FillW'(DEPTH);

  logic             rise;
  logic [BW-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, pop, push, drop;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (event_i),
    .rise_o  (rise)
  );

  always_comb begin
    empty = (fill_q == '0);
    full  = (fill_q == FillFull);
    pop   = ~empty & ts_ready_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push  = rise & (~full | pop);
    drop  = rise & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      fill_d = fill_q + FillW'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - FillW'(1);
    end

    ovf_d = ovf_q;
    if (clear_ovf_i) ovf_d = 1'b0;
    if (drop)        ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; validity is carried by fill_q alone.
  // With push and pop at full, wr_ptr equals rd_ptr and the popped head is overwritten.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= counter_val_i;
    end
  end

  assign ts_valid_o = ~empty;
  assign ts_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign fill_o     = fill_q;
  assign overflow_o = ovf_q;

endmodule
